dut_if_arbiter: RTL and testbench
=================================

// Module: dut_if_arbiter
// PURPOSE
//  Shares one DUT request/response channel between N_REQ requester ports of the
//  multi-interface bench/DUT. Arbitrates requests round-robin into a registered
//  downstream slot, tags each with the requester ID and tracks outstanding
//  transactions. Routes each DUT response back to the requester named by its ID.
// PARAMETERS
//  N_REQ    4   number of requester ports (2..16)
//  DATA_W   32  request/response payload width
//  MAX_OUT  8   max accepted-but-unanswered transactions (1..255)
//  ID_W     $clog2(N_REQ)  requester ID width (derived; do not override)
// PORTS
//  clk          in   1             single clock, all logic rising-edge
//  rst_n        in   1             asynchronous active-low reset
//  s_req_valid  in   N_REQ         per-requester request valid
//  s_req_ready  out  N_REQ         per-requester accept (one-hot or zero)
//  s_req_data   in   N_REQ*DATA_W  packed payloads, [i*DATA_W +: DATA_W]
//  m_req_valid  out  1             downstream request valid (registered)
//  m_req_ready  in   1             DUT accepts request
//  m_req_data   out  DATA_W        registered payload
//  m_req_id     out  ID_W          index of the granted requester
//  m_rsp_valid  in   1             DUT response valid (no backpressure)
//  m_rsp_id     in   ID_W          response destination
//  m_rsp_data   in   DATA_W        response payload
//  s_rsp_valid  out  N_REQ         one-hot response strobe, registered
//  s_rsp_data   out  DATA_W        shared response bus, registered
//  outstanding  out  8             current outstanding count
//  err          out  1             sticky: underflow or bad response ID
// BEHAVIOUR
//  Reset: all outputs 0; rr pointer = 0; state EMPTY. Reset mid-transfer drops
//   the held request and clears the count; no response is generated.
//  Slot FSM: EMPTY -> FULL when a grant loads the slot; FULL -> EMPTY on
//   m_req_valid&&m_req_ready with no reload; FULL -> FULL when handshake and
//   reload occur in the same cycle (back-to-back, 1 req/clk).
//  can_load = (EMPTY || m_req_ready) && (outstanding < MAX_OUT) && |s_req_valid.
//  Grant: winner = first valid index at or after ptr, wrapping N_REQ-1 -> 0.
//   s_req_ready[winner]=1 combinationally in the can_load cycle only. The slot
//   captures data and id at the edge. ptr <= winner+1 (mod N_REQ).
//  Slot output is stable while m_req_valid && !m_req_ready (AXI-style hold).
//  outstanding: +1 on upstream accept, -1 on m_rsp_valid. Both in one cycle:
//   unchanged. At MAX_OUT no ready is given; a same-cycle response does not
//   free a grant until the next cycle.
//  Response: 1-cycle latency. s_rsp_valid[m_rsp_id] and s_rsp_data are
//   registered. s_rsp_data holds its last value when no response is present.
//  m_rsp_id >= N_REQ: response dropped, err set, count still decremented.
//   Response while outstanding==0: dropped, err set, count stays 0.
//  err clears only on reset.
// STRUCTURE
//  Package dut_arb_pkg: N_REQ/DATA_W defaults, ID_W, typedef slot_state_e
//   {EMPTY, FULL}, typedef req_slot_t {data, id}.
//  Sub-module rr_arbiter (N, ptr in, req vector in -> one-hot gnt, gnt_idx,
//   any): purely combinational. Pointer register lives in dut_if_arbiter.
// TESTING
//  1. Only req0 valid, data=32'hA5A5_0001, m_req_ready=1 -> s_req_ready=0001 in
//     that cycle, next cycle m_req_valid=1, data A5A5_0001, id=0.
//  2. All 4 valid continuously, m_req_ready=1 -> grants 0,1,2,3,0 on successive
//     clocks. With MAX_OUT=8 and no responses, ready stops after 8 grants and
//     outstanding=8.
//  3. Slot FULL, m_req_ready=0 for 5 cycles -> m_req_data/id held constant,
//     all s_req_ready=0. Then ready=1 -> handshake, and reload in the same cycle.
//  4. m_rsp_valid with id=2, data=32'hDEAD_BEEF -> next cycle s_rsp_valid=0100,
//     s_rsp_data=DEADBEEF, outstanding decremented. Same-cycle accept+rsp ->
//     count unchanged.
//  5. Response at outstanding=0, and response with id=5 (N_REQ=4) -> err=1,
//     no s_rsp_valid, count not negative.
//  6. Assert rst_n=0 mid-stream with the slot FULL -> m_req_valid, outstanding
//     and err all 0 asynchronously. The next grant starts from requester 0.

Source files
------------

// File: rtl/dut_arb_pkg.sv
// Shared defaults and types for the requester/DUT channel arbiter.
// The bench reuses req_slot_t for its expected-request queue.
package dut_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int DATA_W_DEF  = 32;
  localparam int MAX_OUT_DEF = 8;
  localparam int ID_W_DEF    = $clog2(N_REQ_DEF);
  localparam int CNT_W       = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [ID_W_DEF-1:0]   id;
  } req_slot_t;

endpackage

// File: rtl/dut_if_arbiter_if.sv
// Bundle of upstream requester, downstream DUT and status signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding bench/DUT side.
interface dut_if_arbiter_if
  import dut_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        s_req_valid;
  logic [N_REQ-1:0]        s_req_ready;
  logic [N_REQ*DATA_W-1:0] s_req_data;
  logic                    m_req_valid;
  logic                    m_req_ready;
  logic [DATA_W-1:0]       m_req_data;
  logic [ID_W-1:0]         m_req_id;
  logic                    m_rsp_valid;
  logic [ID_W-1:0]         m_rsp_id;
  logic [DATA_W-1:0]       m_rsp_data;
  logic [N_REQ-1:0]        s_rsp_valid;
  logic [DATA_W-1:0]       s_rsp_data;
  logic [CNT_W-1:0]        outstanding;
  logic                    err;

  modport slave (
    input  s_req_valid, s_req_data, m_req_ready, m_rsp_valid, m_rsp_id, m_rsp_data,
    output s_req_ready, m_req_valid, m_req_data, m_req_id, s_rsp_valid, s_rsp_data,
           outstanding, err
  );

  modport master (
    output s_req_valid, s_req_data, m_req_ready, m_rsp_valid, m_rsp_id, m_rsp_data,
    input  s_req_ready, m_req_valid, m_req_data, m_req_id, s_rsp_valid, s_rsp_data,
           outstanding, err
  );

endinterface

// File: rtl/dut_if_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from N-1 back to 0. The pointer register is owned by the caller.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/dut_if_arbiter.sv
// Shares one DUT request/response channel between N_REQ requesters: round-robin
// grant into a registered slot, outstanding tracking, and ID-routed responses.
module dut_if_arbiter
  import dut_arb_pkg::*;
#(
  parameter  int N_REQ   = N_REQ_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int MAX_OUT = MAX_OUT_DEF,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input logic              clk,
  input logic              rst_n,
  dut_if_arbiter_if.slave  bus
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
  } slot_t;

  slot_state_e       state, state_nxt;
  slot_t             slot;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   gnt_idx;
  logic [N_REQ-1:0]  gnt;
  logic              any;
  logic [CNT_W-1:0]  count;
  logic              err_q;
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              can_load, handshake, dec, rsp_bad, rsp_route;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .ptr     (ptr),
    .req     (bus.s_req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // A response arriving with nothing outstanding, or naming a missing port, is dropped.
  always_comb begin
    can_load  = (state == EMPTY || bus.m_req_ready) && (count < CNT_W'(MAX_OUT)) && any;
    handshake = (state == FULL) && bus.m_req_ready;
    dec       = bus.m_rsp_valid && (count != '0);
    rsp_bad   = bus.m_rsp_valid && ((count == '0) || (int'(bus.m_rsp_id) >= N_REQ));
    rsp_route = bus.m_rsp_valid && !rsp_bad;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (can_load) state_nxt = FULL;
      FULL:    if (handshake && !can_load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      slot  <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (can_load) begin
        slot.data <= bus.s_req_data[int'(gnt_idx)*DATA_W +: DATA_W];
        slot.id   <= gnt_idx;
        ptr       <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // Accept and response in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      if (can_load && !dec)      count <= count + 1'b1;
      else if (!can_load && dec) count <= count - 1'b1;
      if (rsp_bad) err_q <= 1'b1;
      rsp_valid_q <= '0;
      if (rsp_route) begin
        rsp_valid_q[bus.m_rsp_id] <= 1'b1;
        rsp_data_q                <= bus.m_rsp_data;
      end
    end
  end

  assign bus.s_req_ready = can_load ? gnt : '0;
  assign bus.m_req_valid = (state == FULL);
  assign bus.m_req_data  = slot.data;
  assign bus.m_req_id    = slot.id;
  assign bus.s_rsp_valid = rsp_valid_q;
  assign bus.s_rsp_data  = rsp_data_q;
  assign bus.outstanding = count;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_dut_if_arbiter.sv
// Random + directed bench for dut_if_arbiter: a transaction-level model predicts
// grants and responses into queues that an independent monitor drains and compares.
module tb_dut_if_arbiter;
  import dut_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MO = 8;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } rsp_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  bit        m_full;
  int        m_ptr;
  int        m_cnt;
  bit        m_err;
  req_slot_t exp_req_q[$];
  rsp_exp_t  exp_rsp_q[$];

  dut_if_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();
  dut_if_arbiter_if #(.N_REQ(3), .DATA_W(DW)) bus3 ();

  dut_if_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Three requesters make ID 3 representable but invalid.
  dut_if_arbiter #(.N_REQ(3), .DATA_W(DW), .MAX_OUT(2)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic rdy,
                               input logic rv, input logic [1:0] rid, input logic [31:0] rd);
    bus.s_req_valid = v;
    bus.s_req_data  = d;
    bus.m_req_ready = rdy;
    bus.m_rsp_valid = rv;
    bus.m_rsp_id    = rid;
    bus.m_rsp_data  = rd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] randData();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = $urandom;
    return d;
  endfunction

  // Reference model: transaction-level view evaluated once per cycle on stable inputs.
  always @(negedge clk) begin
    int          win;
    bit          can, drop;
    logic [1:0]  j;
    logic [N-1:0] exp_rdy;
    if (!rst_n) begin
      m_full = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
      exp_req_q.delete();
      exp_rsp_q.delete();
    end else begin
      checkOutput("outstanding", 64'(bus.outstanding), 64'(m_cnt));
      checkOutput("err", 64'(bus.err), 64'(m_err));
      checkOutput("m_req_valid", 64'(bus.m_req_valid), 64'(m_full));
      win = -1;
      for (int k = 0; k < N; k++) begin
        j = 2'((m_ptr + k) % N);
        if (win < 0 && bus.s_req_valid[j]) win = int'(j);
      end
      can = (!m_full || bus.m_req_ready) && (m_cnt < MO) && (win >= 0);
      exp_rdy = can ? N'(1 << win) : '0;
      checkOutput("s_req_ready", 64'(bus.s_req_ready), 64'(exp_rdy));
      if (can) exp_req_q.push_back('{data: bus.s_req_data[win*DW +: DW], id: 2'(win)});
      drop = 0;
      if (bus.m_rsp_valid) begin
        if (m_cnt == 0 || int'(bus.m_rsp_id) >= N) drop = 1;
        if (drop) m_err = 1;
        else exp_rsp_q.push_back('{id: int'(bus.m_rsp_id), data: bus.m_rsp_data, due: cyc + 1});
      end
      m_cnt = m_cnt + (can ? 1 : 0) - ((bus.m_rsp_valid && m_cnt > 0) ? 1 : 0);
      if (can) begin
        m_full = 1;
        m_ptr  = (win + 1) % N;
      end else if (m_full && bus.m_req_ready) begin
        m_full = 0;
      end
    end
  end

  // Monitor: consumes predictions whenever the DUT presents a request or response.
  always @(negedge clk) begin
    req_slot_t e;
    rsp_exp_t  r;
    if (rst_n) begin
      if (bus.m_req_valid && bus.m_req_ready) begin
        if (exp_req_q.size() == 0) begin
          checkOutput("req_unexpected_id", 64'(bus.m_req_id), 64'hFFFF);
        end else begin
          e = exp_req_q.pop_front();
          checkOutput("m_req_data", 64'(bus.m_req_data), 64'(e.data));
          checkOutput("m_req_id", 64'(bus.m_req_id), 64'(e.id));
        end
      end
      while (exp_rsp_q.size() > 0 && exp_rsp_q[0].due < cyc) begin
        r = exp_rsp_q.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL rsp_missing: got no strobe, expected id %0d data %0h", r.id, r.data);
      end
      if (bus.s_rsp_valid != '0) begin
        if (exp_rsp_q.size() == 0 || exp_rsp_q[0].due != cyc) begin
          checkOutput("rsp_unexpected", 64'(bus.s_rsp_valid), 64'h0);
        end else begin
          r = exp_rsp_q.pop_front();
          checkOutput("s_rsp_valid", 64'(bus.s_rsp_valid), 64'(1 << r.id));
          checkOutput("s_rsp_data", 64'(bus.s_rsp_data), 64'(r.data));
        end
      end
    end
  end

  initial begin
    logic [N*DW-1:0] d;
    int guard;
    bus.s_req_valid  = '0;  bus.s_req_data  = '0;  bus.m_req_ready  = 1'b0;
    bus.m_rsp_valid  = 1'b0; bus.m_rsp_id   = '0;  bus.m_rsp_data   = '0;
    bus3.s_req_valid = '0;  bus3.s_req_data = '0;  bus3.m_req_ready = 1'b0;
    bus3.m_rsp_valid = 1'b0; bus3.m_rsp_id  = '0;  bus3.m_rsp_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_m_req_valid", 64'(bus.m_req_valid), 64'h0);
    checkOutput("rst_outstanding", 64'(bus.outstanding), 64'h0);
    checkOutput("rst_s_rsp_valid", 64'(bus.s_rsp_valid), 64'h0);
    rst_n = 1'b1;

    // Single requester grant and capture.
    d = '0; d[31:0] = 32'hA5A5_0001;
    applyStimulus(4'b0001, d, 1'b1, 1'b0, 2'd0, 32'h0);
    checkOutput("t1_valid", 64'(bus.m_req_valid), 64'h1);
    checkOutput("t1_data", 64'(bus.m_req_data), 64'hA5A5_0001);
    checkOutput("t1_id", 64'(bus.m_req_id), 64'h0);
    applyStimulus(4'b0000, '0, 1'b1, 1'b1, 2'd0, 32'h1111_0000);
    checkOutput("t1_rsp_valid", 64'(bus.s_rsp_valid), 64'h1);
    checkOutput("t1_rsp_data", 64'(bus.s_rsp_data), 64'h1111_0000);

    // Hold under backpressure, then handshake with same-cycle reload.
    d = '0; d[63:32] = 32'h0000_B001;
    applyStimulus(4'b0010, d, 1'b0, 1'b0, 2'd0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, randData(), 1'b0, 1'b0, 2'd0, 32'h0);
      checkOutput("t3_hold_data", 64'(bus.m_req_data), 64'h0000_B001);
      checkOutput("t3_hold_id", 64'(bus.m_req_id), 64'h1);
      checkOutput("t3_no_ready", 64'(bus.s_req_ready), 64'h0);
    end
    d = randData();
    applyStimulus(4'b1111, d, 1'b1, 1'b0, 2'd0, 32'h0);
    checkOutput("t3_reload_id", 64'(bus.m_req_id), 64'h2);
    checkOutput("t3_reload_data", 64'(bus.m_req_data), 64'(d[95:64]));
    checkOutput("t3_count", 64'(bus.outstanding), 64'h2);

    // Routed response, then accept and response in one cycle.
    applyStimulus(4'b0000, '0, 1'b1, 1'b1, 2'd2, 32'hDEAD_BEEF);
    checkOutput("t4_rsp_valid", 64'(bus.s_rsp_valid), 64'h4);
    checkOutput("t4_rsp_data", 64'(bus.s_rsp_data), 64'hDEAD_BEEF);
    checkOutput("t4_count", 64'(bus.outstanding), 64'h1);
    applyStimulus(4'b0001, randData(), 1'b1, 1'b1, 2'd1, 32'h1234_5678);
    checkOutput("t4_same_cycle_count", 64'(bus.outstanding), 64'h1);
    checkOutput("t4_same_cycle_rsp", 64'(bus.s_rsp_valid), 64'h2);

    // Underflow response sets err and is dropped.
    applyStimulus(4'b0000, '0, 1'b1, 1'b1, 2'd3, 32'h0000_0003);
    checkOutput("t5_drained", 64'(bus.outstanding), 64'h0);
    applyStimulus(4'b0000, '0, 1'b1, 1'b1, 2'd1, 32'h0BAD_0001);
    checkOutput("t5_err", 64'(bus.err), 64'h1);
    checkOutput("t5_no_rsp", 64'(bus.s_rsp_valid), 64'h0);
    checkOutput("t5_count", 64'(bus.outstanding), 64'h0);
    applyStimulus(4'b0000, '0, 1'b1, 1'b0, 2'd0, 32'h0);

    // Out-of-range response ID on the three-port instance.
    bus3.s_req_valid = 3'b001; bus3.m_req_ready = 1'b1;
    @(posedge clk); #1;
    bus3.s_req_valid = 3'b000;
    checkOutput("bad_id_count_pre", 64'(bus3.outstanding), 64'h1);
    bus3.m_rsp_valid = 1'b1; bus3.m_rsp_id = 2'd3; bus3.m_rsp_data = 32'hCAFE_0003;
    @(posedge clk); #1;
    bus3.m_rsp_valid = 1'b0;
    checkOutput("bad_id_err", 64'(bus3.err), 64'h1);
    checkOutput("bad_id_no_rsp", 64'(bus3.s_rsp_valid), 64'h0);
    checkOutput("bad_id_count", 64'(bus3.outstanding), 64'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom), randData(), 1'(($urandom % 4) != 0),
                    1'((m_cnt > 0) ? ($urandom % 3 == 0) : ($urandom % 16 == 0)),
                    2'($urandom % N), $urandom);
    end

    // Async reset with the slot full.
    guard = 0;
    while (m_cnt > 0 && guard < 40) begin
      applyStimulus(4'b0000, '0, 1'b1, 1'b1, 2'd0, $urandom);
      guard++;
    end
    checkOutput("drain_guard", 64'(m_cnt), 64'h0);
    applyStimulus(4'b1111, randData(), 1'b0, 1'b0, 2'd0, 32'h0);
    checkOutput("t6_full", 64'(bus.m_req_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_valid", 64'(bus.m_req_valid), 64'h0);
    checkOutput("t6_count", 64'(bus.outstanding), 64'h0);
    checkOutput("t6_err", 64'(bus.err), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Back-to-back grants from requester 0 until MAX_OUT stops them.
    for (int k = 0; k < MO; k++) begin
      applyStimulus(4'b1111, randData(), 1'b1, 1'b0, 2'd0, 32'h0);
      checkOutput("t2_grant_id", 64'(bus.m_req_id), 64'(k % N));
      checkOutput("t2_count", 64'(bus.outstanding), 64'(k + 1));
    end
    checkOutput("t2_ready_at_max", 64'(bus.s_req_ready), 64'h0);
    applyStimulus(4'b1111, randData(), 1'b1, 1'b0, 2'd0, 32'h0);
    checkOutput("t2_slot_drained", 64'(bus.m_req_valid), 64'h0);
    checkOutput("t2_count_held", 64'(bus.outstanding), 64'h8);
    applyStimulus(4'b1111, randData(), 1'b1, 1'b1, 2'd0, 32'h7777_0000);
    checkOutput("t2_no_grant_same_cycle", 64'(bus.m_req_valid), 64'h0);
    checkOutput("t2_count_dec", 64'(bus.outstanding), 64'h7);
    repeat (3) applyStimulus(4'b0000, '0, 1'b1, 1'b0, 2'd0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
